// File: rtl/wakeup_issue_queue.sv
// Issue queue with multi-port operand wakeup, age-ordered select and flush.
// Sits between the renamer and one functional unit.
module wakeup_issue_queue #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 8,
  parameter int NUM_WAKEUP   = 2,
  localparam int CW = $clog2(QUEUE_SIZE + 1)
) (
  input  logic clk,
  input  logic rst_n,

  input  logic enq_valid,
  output logic enq_ready,
  input  logic [INST_ID_BITS-1:0] enq_inst_id,
  input  logic [31:0] enq_inst,
  input  logic [MAX_OPERANDS-1:0] enq_op_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] enq_op_prn,
  input  logic [MAX_OPERANDS-1:0][63:0] enq_op_value,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] enq_out_prn,
  input  logic [63:0] enq_pc,

  input  logic [NUM_WAKEUP-1:0] wk_valid,
  input  logic [NUM_WAKEUP-1:0][PRN_BITS-1:0] wk_prn,
  input  logic [NUM_WAKEUP-1:0][63:0] wk_value,

  input  logic flush,

  output logic iss_valid,
  input  logic iss_ready,
  output logic [INST_ID_BITS-1:0] iss_inst_id,
  output logic [31:0] iss_inst,
  output logic [MAX_OPERANDS-1:0][63:0] iss_op,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] iss_out_prn,
  output logic [63:0] iss_pc,

  output logic [CW-1:0] count
);

  logic [QUEUE_SIZE-1:0] occ;
  logic [MAX_OPERANDS-1:0] rdy [QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][63:0] opv [QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] opp [QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst [QUEUE_SIZE];
  logic [INST_ID_BITS-1:0] eid [QUEUE_SIZE];
  logic [31:0] einst [QUEUE_SIZE];
  logic [63:0] epc [QUEUE_SIZE];
  // older[k][j] set means slot j was enqueued before slot k
  logic [QUEUE_SIZE-1:0] older [QUEUE_SIZE];

  logic [QUEUE_SIZE-1:0] able;
  logic [QUEUE_SIZE-1:0] sel;
  logic [QUEUE_SIZE-1:0] enq_oh;
  logic [QUEUE_SIZE-1:0] occ_nxt;
  logic [CW-1:0] count_nxt;
  logic enq_fire;
  logic iss_fire;

  logic [MAX_OPERANDS-1:0] wk_hit [QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][63:0] wk_v [QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0] byp_hit;
  logic [MAX_OPERANDS-1:0][63:0] byp_v;

  assign enq_ready = (count != CW'(QUEUE_SIZE));
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign iss_valid = |able;
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    able = '0;
    for (int k = 0; k < QUEUE_SIZE; k++)
      able[k] = occ[k] & (&rdy[k]);
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < QUEUE_SIZE; k++)
      sel[k] = able[k] & ~|(older[k] & able);
  end

  always_comb begin
    iss_inst_id = '0;
    iss_inst    = '0;
    iss_op      = '0;
    iss_out_prn = '0;
    iss_pc      = '0;
    for (int k = 0; k < QUEUE_SIZE; k++) begin
      if (sel[k]) begin
        iss_inst_id = iss_inst_id | eid[k];
        iss_inst    = iss_inst | einst[k];
        iss_op      = iss_op | opv[k];
        iss_out_prn = iss_out_prn | dst[k];
        iss_pc      = iss_pc | epc[k];
      end
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    enq_oh = '0;
    for (int k = 0; k < QUEUE_SIZE; k++) begin
      if (!occ[k] && !found) begin
        enq_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // descending scan so the lowest matching port index wins
  always_comb begin
    for (int k = 0; k < QUEUE_SIZE; k++) begin
      wk_hit[k] = '0;
      wk_v[k]   = '0;
      for (int m = 0; m < MAX_OPERANDS; m++) begin
        for (int j = NUM_WAKEUP - 1; j >= 0; j--) begin
          if (wk_valid[j] && wk_prn[j] == opp[k][m]) begin
            wk_hit[k][m] = 1'b1;
            wk_v[k][m]   = wk_value[j];
          end
        end
      end
    end
  end

  always_comb begin
    byp_hit = '0;
    byp_v   = '0;
    for (int m = 0; m < MAX_OPERANDS; m++) begin
      for (int j = NUM_WAKEUP - 1; j >= 0; j--) begin
        if (wk_valid[j] && wk_prn[j] == enq_op_prn[m]) begin
          byp_hit[m] = 1'b1;
          byp_v[m]   = wk_value[j];
        end
      end
    end
  end

  always_comb begin
    occ_nxt   = occ;
    count_nxt = count;
    if (flush) begin
      occ_nxt   = '0;
      count_nxt = '0;
    end else begin
      if (iss_fire)
        occ_nxt = occ_nxt & ~sel;
      if (enq_fire)
        occ_nxt = occ_nxt | enq_oh;
      count_nxt = count + CW'(enq_fire) - CW'(iss_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= '0;
      count <= '0;
      for (int k = 0; k < QUEUE_SIZE; k++) begin
        rdy[k]   <= '0;
        opv[k]   <= '0;
        opp[k]   <= '0;
        dst[k]   <= '0;
        eid[k]   <= '0;
        einst[k] <= '0;
        epc[k]   <= '0;
        older[k] <= '0;
      end
    end else begin
      occ   <= occ_nxt;
      count <= count_nxt;
      for (int k = 0; k < QUEUE_SIZE; k++) begin
        for (int m = 0; m < MAX_OPERANDS; m++) begin
          if (occ[k] && !rdy[k][m] && wk_hit[k][m]) begin
            rdy[k][m] <= 1'b1;
            opv[k][m] <= wk_v[k][m];
          end
        end
      end
      if (enq_fire) begin
        for (int k = 0; k < QUEUE_SIZE; k++)
          older[k] <= older[k] & ~enq_oh;
        for (int k = 0; k < QUEUE_SIZE; k++) begin
          if (enq_oh[k]) begin
            older[k] <= occ & ~enq_oh;
            eid[k]   <= enq_inst_id;
            einst[k] <= enq_inst;
            epc[k]   <= enq_pc;
            opp[k]   <= enq_op_prn;
            dst[k]   <= enq_out_prn;
            for (int m = 0; m < MAX_OPERANDS; m++) begin
              rdy[k][m] <= enq_op_ready[m] | byp_hit[m];
              opv[k][m] <= enq_op_ready[m] ? enq_op_value[m] : byp_v[m];
            end
          end
        end
      end
    end
  end

endmodule
